// File: rtl/mesm6_pkg.sv
// Shared definitions for the MESM-6 memory arbiter: default bus widths and
// the arbiter FSM state encoding.
package mesm6_pkg;

    localparam int ADDR_BITS_DEF = 15;
    localparam int WORD_BITS_DEF = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INSN = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mesm6_ibuf.sv
// One-word instruction buffer (valid, tag, word). Filled on every memory
// instruction fetch, invalidated by a data write to the buffered address.
// Only instantiated when MESM6_IBUF_EN is defined.
module mesm6_ibuf
    import mesm6_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_fill,
    input  logic [ADDR_BITS-1:0] i_fill_addr,
    input  logic [WORD_BITS-1:0] i_fill_data,
    input  logic                 i_inval,
    input  logic [ADDR_BITS-1:0] i_inval_addr,
    input  logic [ADDR_BITS-1:0] i_lookup_addr,
    output logic                 o_hit,
    output logic [WORD_BITS-1:0] o_data
);

    logic                 r_valid;
    logic [ADDR_BITS-1:0] r_tag;
    logic [WORD_BITS-1:0] r_word;

    // Buffer state: fill takes priority; a write to the tagged address drops it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_word  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_addr;
            r_word  <= i_fill_data;
        end else if (i_inval && (i_inval_addr == r_tag)) begin
            r_valid <= 1'b0;
        end
    end

    // Combinational lookup against the live fetch address
    always_comb begin
        o_hit  = r_valid && (r_tag == i_lookup_addr);
        o_data = r_word;
    end

endmodule

// File: rtl/mesm6_memarb.sv
// MESM-6 memory arbiter: merges the core's instruction and data buses onto a
// single-port memory. A request group (fetch/read/write) is latched in IDLE,
// serviced data-first, and both done strobes are released together in DONE.
// Optional instruction buffer: define MESM6_IBUF_EN.
module mesm6_memarb
    import mesm6_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int WORD_BITS = WORD_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    // instruction bus
    input  logic                 ibus_fetch,
    input  logic [ADDR_BITS-1:0] ibus_addr,
    output logic [WORD_BITS-1:0] ibus_input,
    output logic                 ibus_done,
    // data bus
    input  logic                 dbus_read,
    input  logic                 dbus_write,
    input  logic [ADDR_BITS-1:0] dbus_addr,
    input  logic [WORD_BITS-1:0] dbus_output,
    output logic [WORD_BITS-1:0] dbus_input,
    output logic                 dbus_done,
    // memory port
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    input  logic                 mem_ack
);

    state_t               r_state;
    state_t               w_next;
    logic                 r_fetch;
    logic                 r_read;
    logic                 r_write;
    logic [ADDR_BITS-1:0] r_iaddr;
    logic [ADDR_BITS-1:0] r_daddr;
    logic [WORD_BITS-1:0] r_wdata;
    logic [WORD_BITS-1:0] r_ibus_in;
    logic [WORD_BITS-1:0] r_dbus_in;
    logic                 w_ibuf_hit;
    logic                 w_dbus_req;

`ifdef MESM6_IBUF_EN
    logic [WORD_BITS-1:0] w_ibuf_data;

    mesm6_ibuf #(
        .ADDR_BITS (ADDR_BITS),
        .WORD_BITS (WORD_BITS)
    ) u_ibuf (
        .clk           (clk),
        .reset         (reset),
        .i_fill        ((r_state == INSN) && mem_ack),
        .i_fill_addr   (r_iaddr),
        .i_fill_data   (mem_rdata),
        .i_inval       ((r_state == DATA) && mem_ack && r_write),
        .i_inval_addr  (r_daddr),
        .i_lookup_addr (ibus_addr),
        .o_hit         (w_ibuf_hit),
        .o_data        (w_ibuf_data)
    );
`else
    assign w_ibuf_hit = 1'b0;
`endif

    assign w_dbus_req = dbus_read || dbus_write;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch: sampled every IDLE cycle, frozen while a group is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch <= 1'b0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_iaddr <= '0;
            r_daddr <= '0;
            r_wdata <= '0;
        end else if (r_state == IDLE) begin
            r_fetch <= ibus_fetch;
            r_read  <= dbus_read;
            r_write <= dbus_write;
            r_iaddr <= ibus_addr;
            r_daddr <= dbus_addr;
            r_wdata <= dbus_output;
        end
    end

    // Read-data capture; a write (even with read also set) leaves dbus_input alone
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ibus_in <= '0;
            r_dbus_in <= '0;
        end else begin
            if ((r_state == DATA) && mem_ack && !r_write) begin
                r_dbus_in <= mem_rdata;
            end
            if ((r_state == INSN) && mem_ack) begin
                r_ibus_in <= mem_rdata;
            end
`ifdef MESM6_IBUF_EN
            if ((r_state == IDLE) && !w_dbus_req && ibus_fetch && w_ibuf_hit) begin
                r_ibus_in <= w_ibuf_data;
            end
`endif
        end
    end

    // Next-state: data first, then fetch; fetch-only buffer hits skip memory
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dbus_req) begin
                    w_next = DATA;
                end else if (ibus_fetch) begin
                    w_next = w_ibuf_hit ? DONE : INSN;
                end
            end
            DATA: begin
                if (mem_ack) begin
                    w_next = r_fetch ? INSN : DONE;
                end
            end
            INSN: begin
                if (mem_ack) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and the latched group
    always_comb begin
        mem_req    = (r_state == DATA) || (r_state == INSN);
        mem_we     = (r_state == DATA) && r_write;
        mem_addr   = (r_state == INSN) ? r_iaddr : r_daddr;
        mem_wdata  = r_wdata;
        ibus_done  = (r_state == DONE) && r_fetch;
        dbus_done  = (r_state == DONE) && (r_read || r_write);
        ibus_input = r_ibus_in;
        dbus_input = r_dbus_in;
    end

endmodule

// File: tb/tb_mesm6_memarb.sv
// Self-checking bench for mesm6_memarb: a transaction-level model (queue of
// pending memory accesses per request group) drives the memory responder and
// is compared against the DUT every cycle; directed scenarios add literal checks.
// Honours MESM6_IBUF_EN for the instruction-buffer expectations.
module tb_mesm6_memarb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ibus_fetch;
    logic [14:0] ibus_addr;
    logic [47:0] ibus_input;
    logic        ibus_done;
    logic        dbus_read;
    logic        dbus_write;
    logic [14:0] dbus_addr;
    logic [47:0] dbus_output;
    logic [47:0] dbus_input;
    logic        dbus_done;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [47:0] mem_wdata;
    logic [47:0] mem_rdata;
    logic        mem_ack;

    mesm6_memarb u_dut (
        .clk         (clk),
        .reset       (reset),
        .ibus_fetch  (ibus_fetch),
        .ibus_addr   (ibus_addr),
        .ibus_input  (ibus_input),
        .ibus_done   (ibus_done),
        .dbus_read   (dbus_read),
        .dbus_write  (dbus_write),
        .dbus_addr   (dbus_addr),
        .dbus_output (dbus_output),
        .dbus_input  (dbus_input),
        .dbus_done   (dbus_done),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        is_fetch;
        logic        we;
        logic [14:0] addr;
        logic [47:0] wdata;
    } acc_t;

    logic [47:0] mem [logic [14:0]];
    acc_t        q[$];
    bit          m_done, m_ifl, m_dfl;
    logic [47:0] m_ibus, m_dbus;
    int          m_wait;
    bit          m_wait_set;
    bit          b_valid;
    logic [14:0] b_tag;
    logic [47:0] b_word;
    int          force_wait = 0;   // -1: random wait states
    int          spur_mode  = 0;   // 0 none, 1 random, 2 always ack while idle
    bit          chk_en     = 0;

    function automatic logic [47:0] rd(input logic [14:0] a);
        if (mem.exists(a)) return mem[a];
        return {8'h5A, 10'(a * 3), a, ~a};
    endfunction

    // One clock: respond to memory, compare, advance the model; returns at posedge+1
    task automatic step();
        acc_t a;
        bit   ack;
        @(negedge clk);
        ack = 1'b0;
        if (q.size() > 0) begin
            if (!m_wait_set) begin
                m_wait     = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                m_wait_set = 1'b1;
            end
            if (m_wait == 0) ack = 1'b1;
            else m_wait--;
        end else if (spur_mode == 2) begin
            ack = 1'b1;
        end else if (spur_mode == 1) begin
            ack = ($urandom_range(0, 3) == 0);
        end
        mem_ack   = ack;
        mem_rdata = (ack && q.size() > 0 && !q[0].we) ? rd(q[0].addr)
                                                      : 48'({$urandom, $urandom});
        #1;
        if (chk_en) begin
            check("mem_req", 64'(mem_req), 64'(q.size() > 0));
            if (q.size() > 0) begin
                check("mem_we", 64'(mem_we), 64'(q[0].we));
                check("mem_addr", 64'(mem_addr), 64'(q[0].addr));
                if (q[0].we) check("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
            end
            check("ibus_done", 64'(ibus_done), 64'(m_done && m_ifl));
            check("dbus_done", 64'(dbus_done), 64'(m_done && m_dfl));
            check("ibus_input", 64'(ibus_input), 64'(m_ibus));
            check("dbus_input", 64'(dbus_input), 64'(m_dbus));
        end
        if (reset) begin
            q.delete();
            m_done = 0; m_ibus = '0; m_dbus = '0; m_wait_set = 0; b_valid = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (q.size() > 0) begin
            if (ack) begin
                a = q.pop_front();
                m_wait_set = 0;
                if (a.is_fetch) begin
                    m_ibus = rd(a.addr);
                    b_valid = 1; b_tag = a.addr; b_word = m_ibus;
                end else if (a.we) begin
                    mem[a.addr] = a.wdata;
                    if (b_valid && b_tag == a.addr) b_valid = 0;
                end else begin
                    m_dbus = rd(a.addr);
                end
                if (q.size() == 0) m_done = 1;
            end
        end else if (ibus_fetch || dbus_read || dbus_write) begin
            m_ifl = ibus_fetch;
            m_dfl = dbus_read || dbus_write;
            if (m_dfl) q.push_back({1'b0, dbus_write, dbus_addr, dbus_output});
            if (ibus_fetch) begin
`ifdef MESM6_IBUF_EN
                if (!m_dfl && b_valid && b_tag == ibus_addr) begin
                    m_ibus = b_word;
                    m_done = 1;
                end else
`endif
                q.push_back({1'b1, 1'b0, ibus_addr, 48'h0});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        ibus_fetch = 0; ibus_addr = '0; dbus_read = 0; dbus_write = 0;
        dbus_addr = '0; dbus_output = '0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pulses, bad_gap;
        bit prev_done, saw_idle;
        clr_inputs();
        reset = 1; mem_ack = 0; mem_rdata = '0;
        step();
        chk_en = 1;
        step();
        // reset values
        check("rst_mem_req", 64'(mem_req), 0);
        check("rst_mem_we", 64'(mem_we), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_ibus_input", 64'(ibus_input), 0);
        check("rst_dbus_input", 64'(dbus_input), 0);
        check("rst_dones", 64'({ibus_done, dbus_done}), 0);
        reset = 0;
        step();

        // single fetch, zero-wait memory
        force_wait = 0;
        mem[15'o100] = 48'o1234;
        ibus_fetch = 1; ibus_addr = 15'o100;
        step();
        clr_inputs();
        check("f1_req", 64'(mem_req), 1);
        check("f1_addr", 64'(mem_addr), 64'(15'o100));
        check("f1_done_early", 64'(ibus_done), 0);
        step();
        check("f1_ibus_done", 64'(ibus_done), 1);
        check("f1_dbus_done", 64'(dbus_done), 0);
        check("f1_ibus_input", 64'(ibus_input), 64'(48'o1234));
        step();
        check("f1_done_once", 64'(ibus_done), 0);

        // data read + fetch, two wait states each
        force_wait = 2;
        mem[5] = 48'h1111_1111_1111;
        mem[6] = 48'h2222_2222_2222;
        dbus_read = 1; dbus_addr = 5; ibus_fetch = 1; ibus_addr = 6;
        step();
        clr_inputs();
        check("rf_addr0", 64'(mem_addr), 5);
        steps(3);
        check("rf_addr1", 64'(mem_addr), 6);
        check("rf_req1", 64'(mem_req), 1);
        steps(2);
        check("rf_nodone", 64'({ibus_done, dbus_done}), 0);
        step();
        check("rf_dones", 64'({ibus_done, dbus_done}), 64'(2'b11));
        check("rf_dbus_input", 64'(dbus_input), 64'(48'h1111_1111_1111));
        check("rf_ibus_input", 64'(ibus_input), 64'(48'h2222_2222_2222));
        step();

        // data write
        force_wait = 0;
        dbus_write = 1; dbus_addr = 7; dbus_output = 48'hAB_CDEF;
        step();
        clr_inputs();
        check("wr_we", 64'(mem_we), 1);
        check("wr_wdata", 64'(mem_wdata), 64'(48'hAB_CDEF));
        check("wr_addr", 64'(mem_addr), 7);
        step();
        check("wr_dbus_done", 64'(dbus_done), 1);
        check("wr_ibus_done", 64'(ibus_done), 0);
        check("wr_dbus_keep", 64'(dbus_input), 64'(48'h1111_1111_1111));
        step();

        // reset in DATA before ack, ack arrives afterwards
        force_wait = 1;
        dbus_read = 1; dbus_addr = 9;
        step();
        clr_inputs();
        reset = 1;
        step();
        reset = 0; spur_mode = 2;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_mid_req", 64'(mem_req), 0);
            check("rst_mid_done", 64'({ibus_done, dbus_done}), 0);
        end
        spur_mode = 0; force_wait = 0;

        // fetch held high across three groups
        ibus_fetch = 1; ibus_addr = 15'o300;
        pulses = 0; bad_gap = 0; prev_done = 0; saw_idle = 1;
        for (int i = 0; i < 20 && pulses < 3; i++) begin
            step();
            if (ibus_done) begin
                if (prev_done || !saw_idle) bad_gap++;
                pulses++;
                saw_idle = 0;
            end else if (!mem_req) begin
                saw_idle = 1;
            end
            prev_done = ibus_done;
        end
        check("hold_pulses", 64'(pulses), 3);
        check("hold_gaps", 64'(bad_gap), 0);
        clr_inputs();
        steps(3);

        // repeated fetch to one address, then write to it and fetch again
        ibus_fetch = 1; ibus_addr = 15'o200;
        steps(3);
        step();
`ifdef MESM6_IBUF_EN
        check("ib_hit_req", 64'(mem_req), 0);
        check("ib_hit_done", 64'(ibus_done), 1);
`else
        check("ib_nobuf_req", 64'(mem_req), 1);
        check("ib_nobuf_done", 64'(ibus_done), 0);
`endif
        clr_inputs();
        steps(4);
        dbus_write = 1; dbus_addr = 15'o200; dbus_output = 48'h0BAD_BEEF;
        step();
        clr_inputs();
        steps(2);
        ibus_fetch = 1; ibus_addr = 15'o200;
        step();
        clr_inputs();
        check("ib_after_wr_req", 64'(mem_req), 1);
        check("ib_after_wr_addr", 64'(mem_addr), 64'(15'o200));
        step();
        check("ib_after_wr_data", 64'(ibus_input), 64'(48'h0BAD_BEEF));
        steps(2);

        // randomized traffic
        force_wait = -1; spur_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            ibus_fetch  = $urandom_range(0, 1) == 1;
            dbus_read   = $urandom_range(0, 3) == 0;
            dbus_write  = $urandom_range(0, 3) == 0;
            ibus_addr   = ($urandom_range(0, 4) == 0) ? 15'o200 : 15'($urandom_range(0, 7));
            dbus_addr   = ($urandom_range(0, 4) == 0) ? 15'o200 : 15'($urandom_range(0, 7));
            dbus_output = 48'({$urandom, $urandom});
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
